// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared constants for the I2C word-reader sequencer: FSM state encodings,
// transfer direction values and the default sensor address.
// No ports (package).
// ----------------------------------------------------------------------------
package i2c_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_PTR  = 3'd1;
  localparam logic [2:0] ST_WR_STOP = 3'd2;
  localparam logic [2:0] ST_RD      = 3'd3;
  localparam logic [2:0] ST_RD_STOP = 3'd4;
  localparam logic [2:0] ST_ABORT   = 3'd5;

  // i2c_read_write encoding
  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  // Thermal sensor 7-bit address
  localparam logic [6:0] DEFAULT_DEVICE_ADDRESS = 7'h33;

  // States in which a nack or an expired timeout sends the sequencer to ABORT.
  function automatic logic is_abortable(input logic [2:0] state);
    return (state == ST_WR_PTR) || (state == ST_WR_STOP) ||
           (state == ST_RD)     || (state == ST_RD_STOP);
  endfunction

endpackage

// File: rtl/i2c_word_assembler.sv
// ----------------------------------------------------------------------------
// i2c_word_assembler
// Packs a stream of received bytes into big-endian 16-bit words. The even
// byte of each pair lands in word_data[15:8], the odd byte in word_data[7:0];
// word_valid pulses the cycle after the odd byte arrives, and word_index
// advances after each word has been presented.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : restart pairing and zero word_index (new operation)
//   byte_valid   : one-cycle strobe, byte_data carries a received byte
//   byte_data    : received byte
//   word_data    : assembled word {first byte, second byte}
//   word_valid   : one-cycle pulse per completed word
//   word_index   : index of word_data within the operation
// ----------------------------------------------------------------------------
module i2c_word_assembler #(
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic [15:0]            word_data,
  output logic                   word_valid,
  output logic [COUNT_WIDTH-1:0] word_index
);

  localparam logic [COUNT_WIDTH-1:0] IDX_ONE = COUNT_WIDTH'(1);

  logic                   phase_q, phase_d;       // 0 = expecting high byte
  logic [15:0]            word_data_q, word_data_d;
  logic                   word_valid_q, word_valid_d;
  logic [COUNT_WIDTH-1:0] word_index_q, word_index_d;

  always_comb begin
    phase_d      = phase_q;
    word_data_d  = word_data_q;
    word_valid_d = 1'b0;
    word_index_d = word_index_q;
    if (clear) begin
      // A fresh operation never inherits a half-built word.
      phase_d      = 1'b0;
      word_index_d = '0;
    end else begin
      // Index moves on only after the word it labels has been shown.
      if (word_valid_q) begin
        word_index_d = word_index_q + IDX_ONE;
      end
      if (byte_valid) begin
        if (!phase_q) begin
          word_data_d[15:8] = byte_data;
        end else begin
          word_data_d[7:0] = byte_data;
          word_valid_d     = 1'b1;
        end
        phase_d = ~phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= 1'b0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      word_index_q <= '0;
    end else begin
      phase_q      <= phase_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      word_index_q <= word_index_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign word_index = word_index_q;

endmodule

// File: rtl/i2c_word_reader.sv
// ----------------------------------------------------------------------------
// i2c_word_reader
// Sequencer in front of i2c_controller that reads N big-endian 16-bit
// registers from the thermal sensor: a write transaction sets the 16-bit
// register pointer, then a read transaction fetches 2*N bytes which are
// assembled into words and streamed out.
//
// Controller handshake: i2c_enable_transfer held high keeps a transaction
// open; each i2c_ack pulse (one cycle) confirms one address or data byte,
// and during a read also marks i2c_received_data valid in that same cycle.
// i2c_nack (one cycle) ends the operation with error and beats a coincident
// ack. After enable is dropped the sequencer waits at least one cycle and
// then for i2c_idle before opening the next transaction or finishing.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, sampled only while idle
//   reg_address         : first register address (latched on start)
//   word_count          : number of words N (latched on start)
//   busy, done, error   : operation status; done/error are one-cycle pulses
//   word_data/valid/index : assembled word stream
//   i2c_*  (out)        : address, direction, tx byte, enable to controller
//   i2c_idle/ack/nack/received_data (in) : controller status
//   state_dbg           : current sequencer state (i2c_pkg ST_* encoding)
// ----------------------------------------------------------------------------
module i2c_word_reader
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS = DEFAULT_DEVICE_ADDRESS,
  parameter int         COUNT_WIDTH    = 10,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            reg_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            word_data,
  output logic                   word_valid,
  output logic [COUNT_WIDTH-1:0] word_index,
  output logic [6:0]             i2c_address,
  output logic                   i2c_read_write,
  output logic [7:0]             i2c_transmit_data,
  output logic                   i2c_enable_transfer,
  input  logic                   i2c_idle,
  input  logic                   i2c_ack,
  input  logic                   i2c_nack,
  input  logic [7:0]             i2c_received_data,
  output logic [2:0]             state_dbg
);

  localparam int             BW           = COUNT_WIDTH + 1;
  localparam int             TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0]  BYTE_ONE     = BW'(1);
  localparam logic [TW-1:0]  TW_ONE       = TW'(1);
  // Timer reads 0 in the first cycle of a state, so reaching this value
  // means TIMEOUT_CYCLES cycles have elapsed without progress.
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]             state_q, state_d;
  logic [7:0]             addr_lo_q, addr_lo_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [1:0]             ptr_acks_q, ptr_acks_d;
  logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
  logic                   rd_addr_seen_q, rd_addr_seen_d;
  logic                   settle_q, settle_d;   // first cycle of a stop/abort wait
  logic                   enable_q, enable_d;
  logic                   rw_q, rw_d;
  logic [7:0]             tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [TW-1:0]          timeout_q, timeout_d;

  logic                   timed_out;
  logic                   byte_valid;
  logic                   asm_clear;
  logic [BW-1:0]          last_byte;

  always_comb begin
    state_d        = state_q;
    addr_lo_d      = addr_lo_q;
    count_d        = count_q;
    ptr_acks_d     = ptr_acks_q;
    byte_cnt_d     = byte_cnt_q;
    rd_addr_seen_d = rd_addr_seen_q;
    settle_d       = 1'b0;
    enable_d       = enable_q;
    rw_d           = rw_q;
    tx_d           = tx_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    byte_valid     = 1'b0;
    asm_clear      = 1'b0;
    timed_out      = (timeout_q == TIMEOUT_LAST);
    last_byte      = {count_q, 1'b0} - BYTE_ONE;

    // An ack landing on the expiry cycle counts as progress.
    if (is_abortable(state_q) && (i2c_nack || (timed_out && !i2c_ack))) begin
      state_d  = ST_ABORT;
      enable_d = 1'b0;
      settle_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            asm_clear = 1'b1;
            if (word_count == '0) begin
              // Nothing to fetch: report completion without touching the bus.
              done_d = 1'b1;
            end else begin
              addr_lo_d  = reg_address[7:0];
              count_d    = word_count;
              ptr_acks_d = 2'd0;
              enable_d   = 1'b1;
              rw_d       = I2C_WRITE;
              tx_d       = reg_address[15:8];
              busy_d     = 1'b1;
              state_d    = ST_WR_PTR;
            end
          end
        end

        ST_WR_PTR: begin
          if (i2c_ack) begin
            ptr_acks_d = ptr_acks_q + 2'd1;
            if (ptr_acks_q == 2'd1) begin
              tx_d = addr_lo_q;
            end else if (ptr_acks_q == 2'd2) begin
              enable_d = 1'b0;
              settle_d = 1'b1;
              state_d  = ST_WR_STOP;
            end
          end
        end

        ST_WR_STOP: begin
          if (!settle_q && i2c_idle) begin
            enable_d       = 1'b1;
            rw_d           = I2C_READ;
            byte_cnt_d     = '0;
            rd_addr_seen_d = 1'b0;
            state_d        = ST_RD;
          end
        end

        ST_RD: begin
          if (i2c_ack) begin
            if (!rd_addr_seen_q) begin
              rd_addr_seen_d = 1'b1;
            end else begin
              byte_valid = 1'b1;
              byte_cnt_d = byte_cnt_q + BYTE_ONE;
              if (byte_cnt_q == last_byte) begin
                enable_d = 1'b0;
                settle_d = 1'b1;
                state_d  = ST_RD_STOP;
              end
            end
          end
        end

        ST_RD_STOP: begin
          if (!settle_q && i2c_idle) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end

        ST_ABORT: begin
          if (!settle_q && i2c_idle) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          enable_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end

    // Timer restarts on any bus response or state change; saturates at expiry.
    if ((state_d != state_q) || i2c_ack || i2c_nack || !busy_q) begin
      timeout_d = '0;
    end else if (timeout_q != TIMEOUT_LAST) begin
      timeout_d = timeout_q + TW_ONE;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_lo_q      <= '0;
      count_q        <= '0;
      ptr_acks_q     <= '0;
      byte_cnt_q     <= '0;
      rd_addr_seen_q <= 1'b0;
      settle_q       <= 1'b0;
      enable_q       <= 1'b0;
      rw_q           <= I2C_WRITE;
      tx_q           <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      timeout_q      <= '0;
    end else begin
      state_q        <= state_d;
      addr_lo_q      <= addr_lo_d;
      count_q        <= count_d;
      ptr_acks_q     <= ptr_acks_d;
      byte_cnt_q     <= byte_cnt_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      settle_q       <= settle_d;
      enable_q       <= enable_d;
      rw_q           <= rw_d;
      tx_q           <= tx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      timeout_q      <= timeout_d;
    end
  end

  i2c_word_assembler #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (byte_valid),
    .byte_data  (i2c_received_data),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_index (word_index)
  );

  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;
  assign i2c_address         = DEVICE_ADDRESS;
  assign i2c_read_write      = rw_q;
  assign i2c_transmit_data   = tx_q;
  assign i2c_enable_transfer = enable_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_i2c_word_reader.sv
// ----------------------------------------------------------------------------
// tb_i2c_word_reader
// Directed bench for i2c_word_reader; the bench plays the role of the I2C
// controller and sensor, driving ack/nack/idle/received_data by hand.
// ----------------------------------------------------------------------------
module tb_i2c_word_reader;
  import i2c_pkg::*;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   reg_address = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done, error;
  logic [15:0]   word_data;
  logic          word_valid;
  logic [CW-1:0] word_index;
  logic [6:0]    i2c_address;
  logic          i2c_read_write;
  logic [7:0]    i2c_transmit_data;
  logic          i2c_enable_transfer;
  logic          i2c_idle = 1'b1;
  logic          i2c_ack = 1'b0;
  logic          i2c_nack = 1'b0;
  logic [7:0]    i2c_received_data = '0;
  logic [2:0]    state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, error_cnt = 0, valid_cnt = 0, enable_cnt = 0;

  i2c_word_reader #(
    .DEVICE_ADDRESS (7'h33),
    .COUNT_WIDTH    (CW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .reg_address         (reg_address),
    .word_count          (word_count),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .word_data           (word_data),
    .word_valid          (word_valid),
    .word_index          (word_index),
    .i2c_address         (i2c_address),
    .i2c_read_write      (i2c_read_write),
    .i2c_transmit_data   (i2c_transmit_data),
    .i2c_enable_transfer (i2c_enable_transfer),
    .i2c_idle            (i2c_idle),
    .i2c_ack             (i2c_ack),
    .i2c_nack            (i2c_nack),
    .i2c_received_data   (i2c_received_data),
    .state_dbg           (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (done)                done_cnt   <= done_cnt + 1;
    if (error)               error_cnt  <= error_cnt + 1;
    if (word_valid)          valid_cnt  <= valid_cnt + 1;
    if (i2c_enable_transfer) enable_cnt <= enable_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic ack_byte(input logic [7:0] d);
    i2c_ack = 1'b1;
    i2c_received_data = d;
    tick();
    i2c_ack = 1'b0;
    i2c_received_data = 8'h00;
  endtask

  task automatic start_op(input logic [15:0] addr, input logic [CW-1:0] n);
    reg_address = addr;
    word_count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_enable_high(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i2c_enable_transfer === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_end(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || error === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Three acks (address, high byte, low byte), then release the bus.
  task automatic drive_pointer_write();
    i2c_idle = 1'b0;
    gap(1); ack_byte(8'h00);
    gap(1); ack_byte(8'h00);
    gap(1); ack_byte(8'h00);
    gap(1);
    i2c_idle = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    gap(2);
    vectors++;
    if ({busy, done, error, word_valid, i2c_enable_transfer, i2c_read_write} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, error, word_valid, i2c_enable_transfer, i2c_read_write});
    end
    vectors++;
    if (word_data !== 16'h0000 || word_index !== '0) begin
      miscompares++;
      $display("FAIL reset_word: got data=%h idx=%0d want 0000/0", word_data, word_index);
    end
    vectors++;
    if (i2c_transmit_data !== 8'h00 || state_dbg !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_tx_state: got tx=%h st=%0d want 00/%0d", i2c_transmit_data, state_dbg, ST_IDLE);
    end
    vectors++;
    if (i2c_address !== 7'h33) begin
      miscompares++;
      $display("FAIL device_address: got %h want 33", i2c_address);
    end
    reset = 1'b0;
    gap(1);
  endtask

  task automatic test_normal_read();
    int d0, e0, v0;
    logic ok;
    d0 = done_cnt; e0 = error_cnt; v0 = valid_cnt;
    start_op(16'h2400, 10'd2);
    vectors++;
    if ({busy, i2c_enable_transfer, i2c_read_write} !== 3'b110 || i2c_transmit_data !== 8'h24) begin
      miscompares++;
      $display("FAIL wr_begin: got busy/en/rw=%b tx=%h want 110/24", {busy, i2c_enable_transfer, i2c_read_write}, i2c_transmit_data);
    end
    i2c_idle = 1'b0;
    gap(1); ack_byte(8'h00);   // address ack
    vectors++;
    if (i2c_transmit_data !== 8'h24) begin
      miscompares++;
      $display("FAIL wr_tx_after_ack1: got %h want 24", i2c_transmit_data);
    end
    // start while busy with different inputs must be ignored
    reg_address = 16'hFFFF; word_count = 10'd5; start = 1'b1;
    gap(1);
    start = 1'b0;
    ack_byte(8'h00);           // high byte ack
    vectors++;
    if (i2c_transmit_data !== 8'h00) begin
      miscompares++;
      $display("FAIL wr_tx_after_ack2: got %h want 00", i2c_transmit_data);
    end
    gap(1); ack_byte(8'h00);   // low byte ack
    vectors++;
    if (i2c_enable_transfer !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_enable_drop: got %b want 0", i2c_enable_transfer);
    end
    gap(2);
    vectors++;
    if (i2c_read_write !== 1'b0 || i2c_enable_transfer !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_stop_hold: got rw=%b en=%b want 0/0", i2c_read_write, i2c_enable_transfer);
    end
    i2c_idle = 1'b1;
    wait_enable_high(ok);
    vectors++;
    if (!ok || i2c_read_write !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_begin: got ok=%b rw=%b want 1/1", ok, i2c_read_write);
    end
    i2c_idle = 1'b0;
    gap(1); ack_byte(8'hEE);   // address ack, data ignored
    gap(1); ack_byte(8'hB3);
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_half_word: got valid=%b want 0", word_valid);
    end
    gap(1); ack_byte(8'h39);
    vectors++;
    if (word_valid !== 1'b1 || word_data !== 16'hB339 || word_index !== 10'd0) begin
      miscompares++;
      $display("FAIL rd_word0: got v=%b data=%h idx=%0d want 1/b339/0", word_valid, word_data, word_index);
    end
    gap(1);
    vectors++;
    if (word_valid !== 1'b0 || word_index !== 10'd1) begin
      miscompares++;
      $display("FAIL rd_word0_after: got v=%b idx=%0d want 0/1", word_valid, word_index);
    end
    ack_byte(8'h74);
    gap(1); ack_byte(8'h40);
    vectors++;
    if (word_valid !== 1'b1 || word_data !== 16'h7440 || word_index !== 10'd1 || i2c_enable_transfer !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_word1: got v=%b data=%h idx=%0d en=%b want 1/7440/1/0", word_valid, word_data, word_index, i2c_enable_transfer);
    end
    gap(1);
    i2c_idle = 1'b1;
    wait_end(ok);
    vectors++;
    if (!ok || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_done: got ok=%b done=%b busy=%b want 1/1/0", ok, done, busy);
    end
    gap(2);
    vectors++;
    if (done_cnt - d0 != 1 || error_cnt - e0 != 0 || valid_cnt - v0 != 2) begin
      miscompares++;
      $display("FAIL rd_pulse_counts: got done=%0d err=%0d words=%0d want 1/0/2", done_cnt - d0, error_cnt - e0, valid_cnt - v0);
    end
  endtask

  task automatic test_addr_nack();
    int d0, e0, v0;
    logic ok;
    d0 = done_cnt; e0 = error_cnt; v0 = valid_cnt;
    start_op(16'h1234, 10'd1);
    i2c_idle = 1'b0;
    gap(1);
    i2c_nack = 1'b1;
    tick();
    i2c_nack = 1'b0;
    vectors++;
    if (i2c_enable_transfer !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL nack_enable_drop: got en=%b busy=%b want 0/1", i2c_enable_transfer, busy);
    end
    gap(2);
    vectors++;
    if (error_cnt - e0 != 0) begin
      miscompares++;
      $display("FAIL nack_error_early: got %0d error pulses want 0 before idle", error_cnt - e0);
    end
    i2c_idle = 1'b1;
    wait_end(ok);
    vectors++;
    if (!ok || error !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nack_error: got ok=%b err=%b busy=%b want 1/1/0", ok, error, busy);
    end
    gap(2);
    vectors++;
    if (error_cnt - e0 != 1 || done_cnt - d0 != 0 || valid_cnt - v0 != 0) begin
      miscompares++;
      $display("FAIL nack_counts: got err=%0d done=%0d words=%0d want 1/0/0", error_cnt - e0, done_cnt - d0, valid_cnt - v0);
    end
  endtask

  task automatic test_zero_count();
    int n0;
    n0 = enable_cnt;
    start_op(16'h0100, 10'd0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || word_index !== 10'd0) begin
      miscompares++;
      $display("FAIL zero_done: got done=%b busy=%b idx=%0d want 1/0/0", done, busy, word_index);
    end
    gap(1);
    vectors++;
    if (done !== 1'b0 || state_dbg !== ST_IDLE) begin
      miscompares++;
      $display("FAIL zero_done_width: got done=%b st=%0d want 0/%0d", done, state_dbg, ST_IDLE);
    end
    gap(1);
    vectors++;
    if (enable_cnt - n0 != 0) begin
      miscompares++;
      $display("FAIL zero_no_bus: got %0d enable cycles want 0", enable_cnt - n0);
    end
  endtask

  task automatic test_timeout();
    int e0, got;
    logic en_mid, en_at;
    e0 = error_cnt; got = -1; en_mid = 1'b0; en_at = 1'b1;
    i2c_idle = 1'b1;
    start_op(16'h5555, 10'd1);  // WR_PTR entered on this edge
    for (int n = 1; n <= 90; n++) begin
      tick();
      if (n == 60) en_mid = i2c_enable_transfer;
      if (error === 1'b1 && got < 0) begin
        got = n;
        en_at = i2c_enable_transfer;
      end
    end
    vectors++;
    if (en_mid !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_still_waiting: got en=%b want 1 at cycle 60", en_mid);
    end
    vectors++;
    if (got < 64 || got > 68) begin
      miscompares++;
      $display("FAIL timeout_error_cycle: got %0d want 64..68", got);
    end
    vectors++;
    if (en_at !== 1'b0 || error_cnt - e0 != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_final: got en=%b errs=%0d busy=%b want 0/1/0", en_at, error_cnt - e0, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int d0, v0;
    logic ok;
    start_op(16'h0010, 10'd2);
    drive_pointer_write();
    wait_enable_high(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL mid_rd_begin: got ok=%b want 1", ok);
    end
    i2c_idle = 1'b0;
    gap(1); ack_byte(8'hEE);
    gap(1); ack_byte(8'hAA);
    gap(1); ack_byte(8'h55);
    vectors++;
    if (word_valid !== 1'b1 || word_data !== 16'hAA55) begin
      miscompares++;
      $display("FAIL mid_word0: got v=%b data=%h want 1/aa55", word_valid, word_data);
    end
    gap(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({busy, done, error, word_valid, i2c_enable_transfer, i2c_read_write} !== 6'b0 ||
        word_data !== 16'h0000 || word_index !== '0 || i2c_transmit_data !== 8'h00 || state_dbg !== ST_IDLE) begin
      miscompares++;
      $display("FAIL mid_reset_values: got flags=%b data=%h idx=%0d tx=%h st=%0d want 000000/0000/0/00/%0d",
               {busy, done, error, word_valid, i2c_enable_transfer, i2c_read_write}, word_data, word_index,
               i2c_transmit_data, state_dbg, ST_IDLE);
    end
    i2c_idle = 1'b1;
    gap(1);
    d0 = done_cnt; v0 = valid_cnt;
    start_op(16'h0020, 10'd1);
    drive_pointer_write();
    wait_enable_high(ok);
    i2c_idle = 1'b0;
    gap(1); ack_byte(8'hEE);
    gap(1); ack_byte(8'h12);
    gap(1); ack_byte(8'h34);
    vectors++;
    if (!ok || word_valid !== 1'b1 || word_data !== 16'h1234 || word_index !== 10'd0) begin
      miscompares++;
      $display("FAIL restart_word: got ok=%b v=%b data=%h idx=%0d want 1/1/1234/0", ok, word_valid, word_data, word_index);
    end
    gap(1);
    i2c_idle = 1'b1;
    wait_end(ok);
    vectors++;
    if (!ok || done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_done: got ok=%b done=%b want 1/1", ok, done);
    end
    gap(2);
    vectors++;
    if (done_cnt - d0 != 1 || valid_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL restart_counts: got done=%0d words=%0d want 1/1", done_cnt - d0, valid_cnt - v0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_normal_read();
    test_addr_nack();
    test_zero_count();
    test_timeout();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
